seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/quotient/remainder width, legal range 4..32.
REQ-002 The block SHALL have parameter FRAC, default 0, fractional quotient bits appended to the dividend, legal range 0..WIDTH-1.
REQ-003 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 The block SHALL have port sgn  input  1  1 = two's-complement mode, 0 = unsigned; sampled with start.
REQ-007 The block SHALL have port a  input  WIDTH  dividend; sampled with start.
REQ-008 The block SHALL have port b  input  WIDTH  divisor; sampled with start.
REQ-009 The block SHALL have port busy  output  1  high from LOAD through DONE inclusive.
REQ-010 The block SHALL have port valid  output  1  one-cycle pulse in DONE; results valid.
REQ-011 The block SHALL have port q  output  WIDTH  quotient, registered.
REQ-012 The block SHALL have port r  output  WIDTH  remainder, registered.
REQ-013 The block SHALL have port dvz  output  1  divide-by-zero flag, registered.
REQ-014 The block SHALL have port ovf  output  1  quotient-overflow flag, registered.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, CALC, FIX, DONE; DONE always returns to IDLE.
REQ-016 In IDLE with start=1, a, b and sgn SHALL be latched and the FSM SHALL enter LOAD next cycle; start outside IDLE SHALL be ignored.
REQ-017 LOAD SHALL convert operands to magnitudes when sgn=1, record result signs, load iteration counter with N=WIDTH+FRAC, and go to DONE with dvz=1 if b==0, else to CALC.
REQ-018 CALC SHALL perform exactly one restoring step per cycle on dividend magnitude << FRAC (N bits): shift, trial-subtract divisor, set quotient bit if no borrow; N cycles, then FIX.
REQ-019 FIX SHALL negate quotient if operand signs differ (sgn=1), give remainder the dividend's sign, and load q, r, ovf registers.
REQ-020 ovf SHALL be 1 when the magnitude quotient does not fit the result range: unsigned > 2^WIDTH-1; signed positive > 2^(WIDTH-1)-1; signed negative > 2^(WIDTH-1); on ovf, q SHALL hold the low WIDTH bits of the signed result.
REQ-021 Latency: with start sampled at edge 0, valid SHALL be high in cycle N+3 for normal division and in cycle 2 for divide-by-zero.
REQ-022 On divide-by-zero, q SHALL be all ones, r SHALL equal latched a, ovf SHALL be 0.
REQ-023 q, r, dvz, ovf SHALL hold their values until the next FIX/LOAD writes them; dvz and ovf SHALL clear when a new request is accepted.
REQ-024 A start asserted in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted (back-to-back issue every N+4 cycles).

Reset
REQ-025 rst SHALL force state IDLE and busy, valid, q, r, dvz, ovf, counter and internal registers to 0 on the next edge, including mid-CALC; rst SHALL take priority over start.

Structure
REQ-026 The state encoding (3-bit) and the WIDTH/FRAC legal-range constants SHALL live in shared package div_pkg.
REQ-027 The shift/trial-subtract register pair SHALL be one sub-module seq_div_dp; FSM and sign handling SHALL stay in seq_divider.

Verification
REQ-028 WIDTH=8, FRAC=0, sgn=0, a=100, b=7 -> valid at cycle 11, q=14, r=2, dvz=0, ovf=0, busy high cycles 1..11.
REQ-029 sgn=1, a=0x9C (-100), b=7 -> q=0xF2 (-14), r=0xFE (-2), ovf=0.
REQ-030 b=0, a=0x55 -> valid at cycle 2, dvz=1, q=0xFF, r=0x55; then a=100, b=7 issued next -> dvz=0.
REQ-031 sgn=1, a=0x80, b=0xFF -> ovf=1, q=0x80; FRAC=4, sgn=0, a=3, b=2 -> q=0x18, r=0, valid at cycle 15; FRAC=4, a=200, b=1 -> ovf=1.
REQ-032 start pulsed in cycles 5 and 11 of an active op -> ignored, single valid; rst asserted in cycle 6 -> busy=0, q=r=0 at cycle 7, no valid pulse.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and the
// legal parameter ranges checked at elaboration time.
package div_pkg;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 32;
    localparam int FRAC_MIN  = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_t;

    // Largest fractional extension allowed for a given operand width.
    function automatic int frac_max(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/seq_div_dp.sv
// Restoring-division datapath: a partial-remainder register and a combined
// dividend/quotient shift register. Each step shifts one dividend bit into
// the remainder, trial-subtracts the divisor and shifts the quotient bit in.
module seq_div_dp #(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [N-1:0]     dvd,
    input  logic [WIDTH-1:0] dvs,
    output logic [N-1:0]     quot,
    output logic [WIDTH-1:0] rem
);

    logic [N-1:0]     dq_q, dq_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic             unused_dp_bits;

    // Next-state for one restoring step, or a fresh load of the operands.
    always_comb begin
        shifted = {rem_q, dq_q[N-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        borrow  = diff[WIDTH+1];
        rem_d   = rem_q;
        dq_d    = dq_q;
        if (load) begin
            rem_d = '0;
            dq_d  = dvd;
        end else if (step) begin
            // Remainder stays below the divisor, so WIDTH bits always suffice.
            rem_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            dq_d  = {dq_q[N-2:0], ~borrow};
        end
    end

    // The top bits are provably zero after selection and are not stored.
    assign unused_dp_bits = ^{shifted[WIDTH], diff[WIDTH]};

    // Register the remainder, dividend/quotient and the latched divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            dq_q  <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            dq_q  <= dq_d;
            if (load) begin
                dvs_q <= dvs;
            end
        end
    end

    assign quot = dq_q;
    assign rem  = rem_q;

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned divider with optional fractional quotient bits.
// Handshake: start is accepted only while idle (busy low); results appear with
// a one-cycle valid pulse and q/r/dvz/ovf hold until the next operation.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dvz,
    output logic             ovf,
    output logic [2:0]       state_dbg
);

    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] ONE    = 1;
    localparam logic [N-1:0] LIM_U  = (ONE << WIDTH) - ONE;
    localparam logic [N-1:0] LIM_SP = (ONE << (WIDTH - 1)) - ONE;
    localparam logic [N-1:0] LIM_SN = ONE << (WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        FRAC < FRAC_MIN || FRAC > frac_max(WIDTH)) begin : g_bad_params
        $error("seq_divider: WIDTH/FRAC outside legal range");
    end

    div_state_t       state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;
    logic             qneg_q, rneg_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, valid_q;
    logic [WIDTH-1:0] q_q, r_q;
    logic             dvz_q, ovf_q;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [N-1:0]     dvd_ext;
    logic [N-1:0]     dp_quot;
    logic [WIDTH-1:0] dp_rem;
    logic [N-1:0]     q_signed;
    logic [WIDTH-1:0] r_signed;
    logic             ovf_d;
    logic             unused_q_hi;

    // Operand magnitudes and the dividend widened and shifted by FRAC.
    always_comb begin
        mag_a   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        mag_b   = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        dvd_ext = '0;
        dvd_ext[WIDTH-1:0] = mag_a;
        dvd_ext = dvd_ext << FRAC;
    end

    seq_div_dp #(
        .WIDTH(WIDTH),
        .N    (N)
    ) u_dp (
        .clk (clk),
        .rst (rst),
        .load(state_q == S_LOAD),
        .step(state_q == S_CALC),
        .dvd (dvd_ext),
        .dvs (mag_b),
        .quot(dp_quot),
        .rem (dp_rem)
    );

    // Sign restoration and range check of the magnitude quotient.
    always_comb begin
        q_signed = qneg_q ? -dp_quot : dp_quot;
        r_signed = rneg_q ? -dp_rem : dp_rem;
        if (!sgn_q) begin
            ovf_d = dp_quot > LIM_U;
        end else if (qneg_q) begin
            ovf_d = dp_quot > LIM_SN;
        end else begin
            ovf_d = dp_quot > LIM_SP;
        end
    end

    // Only the low WIDTH bits of the signed quotient are reported.
    assign unused_q_hi = ^q_signed;

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dvz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sgn_q   <= sgn;
                        dvz_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    qneg_q <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rneg_q <= sgn_q & a_q[WIDTH-1];
                    cnt_q  <= CW'(N);
                    if (b_q == '0) begin
                        dvz_q   <= 1'b1;
                        q_q     <= '1;
                        r_q     <= a_q;
                        ovf_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    q_q     <= q_signed[WIDTH-1:0];
                    r_q     <= r_signed;
                    ovf_q   <= ovf_d;
                    valid_q <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign q         = q_q;
    assign r         = r_q;
    assign dvz       = dvz_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: one WIDTH=8/FRAC=0 instance and one
// WIDTH=8/FRAC=4 instance sharing clock, reset and operand buses.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start4;
    logic       sgn;
    logic [7:0] a, b;

    logic       busy, valid, dvz, ovf;
    logic [7:0] q, r;
    logic [2:0] state_dbg;

    logic       busy4, valid4, dvz4, ovf4;
    logic [7:0] q4, r4;
    logic [2:0] state_dbg4;

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int vbase;

    // Clock generation.
    always #5 clk = ~clk;

    // Count valid pulses of the FRAC=0 instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt++;
    end

    seq_divider #(.WIDTH(8), .FRAC(0)) dut (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
        .busy(busy), .valid(valid), .q(q), .r(r), .dvz(dvz), .ovf(ovf),
        .state_dbg(state_dbg)
    );

    seq_divider #(.WIDTH(8), .FRAC(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sgn(sgn), .a(a), .b(b),
        .busy(busy4), .valid(valid4), .q(q4), .r(r4), .dvz(dvz4), .ovf(ovf4),
        .state_dbg(state_dbg4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a request for one sampling edge; returns in cycle 1 (LOAD).
    task automatic issue(input bit sel4, input logic s, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        sgn = s;
        a   = av;
        b   = bv;
        if (sel4) start4 = 1'b1;
        else      start  = 1'b1;
        tick();
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start4 = 1'b0; sgn = 1'b0; a = '0; b = '0;
        ticks(2);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dvz", dvz, 0);
        check("rst_ovf", ovf, 0);
        check("rst_state", state_dbg, 0);
        check("rst_busy4", busy4, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 100 / 7 unsigned: busy cycles 1..11, valid only in cycle 11.
        issue(0, 0, 8'd100, 8'd7);
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("u_busy_c%0d", k), busy, (k <= 11) ? 1 : 0);
            check($sformatf("u_valid_c%0d", k), valid, (k == 11) ? 1 : 0);
            if (k == 1)  check("u_state_load", state_dbg, 1);
            if (k == 2)  check("u_state_calc", state_dbg, 2);
            if (k == 10) check("u_state_fix", state_dbg, 3);
            if (k == 11) begin
                check("u_state_done", state_dbg, 4);
                check("u_q", q, 14);
                check("u_r", r, 2);
                check("u_dvz", dvz, 0);
                check("u_ovf", ovf, 0);
            end
            tick();
        end

        // -100 / 7 signed.
        issue(0, 1, 8'h9C, 8'd7);
        ticks(9);
        check("s_valid_c10", valid, 0);
        tick();
        check("s_valid_c11", valid, 1);
        check("s_q", q, 8'hF2);
        check("s_r", r, 8'hFE);
        check("s_ovf", ovf, 0);

        // Start raised in DONE is ignored, held into IDLE it is accepted: 0x55 / 0.
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 8'h55; b = 8'h00;
        tick();
        check("done_start_ignored_busy", busy, 0);
        check("done_start_ignored_state", state_dbg, 0);
        tick();
        start = 1'b0;
        check("z_busy_c1", busy, 1);
        check("z_valid_c1", valid, 0);
        tick();
        check("z_valid_c2", valid, 1);
        check("z_dvz", dvz, 1);
        check("z_q", q, 8'hFF);
        check("z_r", r, 8'h55);
        check("z_ovf", ovf, 0);
        tick();
        check("z_valid_c3", valid, 0);
        check("z_dvz_hold", dvz, 1);
        check("z_q_hold", q, 8'hFF);

        // Following request clears dvz on acceptance.
        issue(0, 0, 8'd100, 8'd7);
        check("n_dvz_clear_c1", dvz, 0);
        ticks(10);
        check("n_valid", valid, 1);
        check("n_q", q, 14);
        check("n_r", r, 2);
        check("n_dvz", dvz, 0);
        tick();

        // -128 / -1 signed overflows.
        issue(0, 1, 8'h80, 8'hFF);
        ticks(10);
        check("o_valid", valid, 1);
        check("o_ovf", ovf, 1);
        check("o_q", q, 8'h80);
        check("o_r", r, 0);
        check("o_dvz", dvz, 0);
        tick();

        // FRAC=4: 3 / 2 = 1.5 -> 0x18, valid in cycle 15.
        issue(1, 0, 8'd3, 8'd2);
        ticks(13);
        check("f_valid_c14", valid4, 0);
        tick();
        check("f_valid_c15", valid4, 1);
        check("f_busy_c15", busy4, 1);
        check("f_q", q4, 8'h18);
        check("f_r", r4, 0);
        check("f_ovf", ovf4, 0);
        tick();

        // FRAC=4: 200 / 1 = 3200 does not fit in 8 bits.
        issue(1, 0, 8'd200, 8'd1);
        ticks(14);
        check("fo_valid", valid4, 1);
        check("fo_ovf", ovf4, 1);
        check("fo_q", q4, 8'h80);
        check("fo_r", r4, 0);
        tick();

        // Starts during CALC (cycle 5) and DONE (cycle 11) are ignored: 50 / 3.
        vbase = valid_cnt;
        issue(0, 0, 8'd50, 8'd3);
        ticks(4);
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd1;
        tick();
        start = 1'b0;
        check("ign_busy_c6", busy, 1);
        ticks(5);
        check("ign_valid_c11", valid, 1);
        check("ign_q", q, 16);
        check("ign_r", r, 2);
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy_c12", busy, 0);
        tick();
        check("ign_busy_c13", busy, 0);
        check("ign_valid_count", valid_cnt - vbase, 1);

        // Reset during CALC: sampled at edge 6, everything clear in cycle 7.
        vbase = valid_cnt;
        issue(0, 0, 8'd100, 8'd7);
        ticks(5);
        check("rc_busy_c6", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rc_busy_c7", busy, 0);
        check("rc_valid_c7", valid, 0);
        check("rc_q_c7", q, 0);
        check("rc_r_c7", r, 0);
        check("rc_state_c7", state_dbg, 0);
        check("rc_q4_c7", q4, 0);
        @(negedge clk);
        rst = 1'b0;
        ticks(8);
        check("rc_no_valid", valid_cnt - vbase, 0);
        check("rc_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
